// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// Holds the datapath width, PC step and the fetch bundle type.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry fetch FIFO between fetch and decode.
// The head always sits in slot 0, so it stays stable under backpressure.
import riscv_pkg::*;

module fetch_buffer (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);
    fetch_entry_t r_e0;
    fetch_entry_t r_e1;
    logic [1:0]   r_count;
    logic         w_pop;

    assign w_pop = i_pop && (r_count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else if (i_push && w_pop) begin
            if (r_count == 2'd2) begin
                r_e0 <= r_e1;
                r_e1 <= i_data;
            end else begin
                r_e0 <= i_data;
            end
        end else if (w_pop) begin
            r_e0    <= r_e1;
            r_count <= r_count - 2'd1;
        end else if (i_push && (r_count != 2'd2)) begin
            if (r_count == 2'd0) begin
                r_e0 <= i_data;
            end else begin
                r_e1 <= i_data;
            end
            r_count <= r_count + 2'd1;
        end
    end

    assign o_head  = r_e0;
    assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, redirect/flush and fetch faults,
// and feeds {pc, instr} to decode through a 2-entry buffer.
import riscv_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault,
    output logic [31:0] fault_pc
);
    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    logic [31:0]  r_pc;
    logic         r_fault;
    logic [31:0]  r_fault_pc;
    logic         w_legal;
    logic         w_pop;
    logic         w_push;
    logic [1:0]   w_count;
    fetch_entry_t w_head;
    fetch_entry_t w_new;

    assign w_legal = (r_pc[1:0] == 2'b00) && (r_pc < PC_LIMIT);
    assign w_pop   = out_valid && out_ready;
    assign w_push  = !r_fault && !redirect_valid && w_legal
                   && ((w_count != 2'd2) || w_pop);
    assign w_new   = '{pc: r_pc, instr: imem_instr};

    fetch_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_new),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Redirect wins over everything and is the only way out of a fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_fault <= 1'b0;
        end else begin
            if (w_push) begin
                r_pc <= r_pc + PC_STEP;
            end
            if (!r_fault && !w_legal) begin
                r_fault    <= 1'b1;
                r_fault_pc <= r_pc;
            end
        end
    end

    assign imem_addr = r_pc;
    assign out_valid = (w_count != 2'd0);
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;
    assign fault     = r_fault;
    assign fault_pc  = r_fault_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory.
// Outputs are sampled on the falling edge; inputs change right after.
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;
    logic [31:0] fault_pc;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:255];

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (256)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    assign imem_instr = mem[imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0053_02b3;
            32'h4:   return 32'h4053_02b3;
            32'h8:   return 32'h0053_0333;
            default: return 32'hA000_0000 | (a >> 2);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = instr_at(32'(i * 4));
        end
        rst            = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) tick();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        rst = 1'b0;

        // streaming, no bubbles
        tick();
        check("seq_valid", {31'b0, out_valid}, 32'd1);
        check("seq_pc0", out_pc, 32'h0);
        check("seq_in0", out_instr, 32'h0053_02b3);
        check("seq_addr", imem_addr, 32'h4);
        tick();
        check("seq_pc4", out_pc, 32'h4);
        check("seq_in4", out_instr, 32'h4053_02b3);
        tick();
        check("seq_pc8", out_pc, 32'h8);
        check("seq_in8", out_instr, 32'h0053_0333);

        // backpressure from reset
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("bp_valid", {31'b0, out_valid}, 32'd1);
        check("bp_pc", out_pc, 32'h0);
        check("bp_instr", out_instr, 32'h0053_02b3);
        check("bp_addr", imem_addr, 32'h8);
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            check("bp_drain_pc", out_pc, 32'(i * 4));
            check("bp_drain_in", out_instr, instr_at(32'(i * 4)));
        end

        // redirect while full
        out_ready = 1'b0;
        repeat (3) tick();
        check("full_valid", {31'b0, out_valid}, 32'd1);
        redirect(32'h20);
        check("rd_bubble", {31'b0, out_valid}, 32'd0);
        check("rd_addr", imem_addr, 32'h20);
        out_ready = 1'b1;
        tick();
        check("rd_valid", {31'b0, out_valid}, 32'd1);
        check("rd_pc", out_pc, 32'h20);
        check("rd_instr", out_instr, instr_at(32'h20));
        tick();
        check("rd_pc2", out_pc, 32'h24);

        // misaligned redirect then recovery
        redirect(32'h22);
        check("mis_valid0", {31'b0, out_valid}, 32'd0);
        check("mis_fault0", {31'b0, fault}, 32'd0);
        tick();
        check("mis_fault", {31'b0, fault}, 32'd1);
        check("mis_fpc", fault_pc, 32'h22);
        check("mis_valid", {31'b0, out_valid}, 32'd0);
        repeat (3) tick();
        check("mis_sticky", {31'b0, fault}, 32'd1);
        check("mis_hold", imem_addr, 32'h22);
        check("mis_valid2", {31'b0, out_valid}, 32'd0);
        redirect(32'h10);
        check("clr_fault", {31'b0, fault}, 32'd0);
        tick();
        check("clr_valid", {31'b0, out_valid}, 32'd1);
        check("clr_pc", out_pc, 32'h10);
        check("clr_instr", out_instr, instr_at(32'h10));

        // run off the end of memory
        redirect(32'h3F0);
        check("end_bubble", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("end_pc", out_pc, 32'h3F0 + 32'(i * 4));
        end
        tick();
        check("end_valid", {31'b0, out_valid}, 32'd0);
        check("end_fault", {31'b0, fault}, 32'd1);
        check("end_fpc", fault_pc, 32'h400);
        check("end_addr", imem_addr, 32'h400);

        // async reset with full buffer and fault raised
        out_ready = 1'b0;
        redirect(32'h3F8);
        repeat (3) tick();
        check("pre_valid", {31'b0, out_valid}, 32'd1);
        check("pre_pc", out_pc, 32'h3F8);
        check("pre_fault", {31'b0, fault}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", {31'b0, out_valid}, 32'd0);
        check("ar_addr", imem_addr, 32'h0);
        check("ar_fault", {31'b0, fault}, 32'd0);
        check("ar_fpc", fault_pc, 32'h0);
        check("ar_pc", out_pc, 32'h0);
        tick();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
